mod_port: RTL and testbench

Single-clock FIFO with write-side status reporting: 32 entries of 32-bit data, plus full, almost-full and overflow flags, an occupancy level and a count of accepted writes. It implements the design-side contract of the FIFO write port used by the write driver/monitor agents. It also provides a minimal read side so the occupancy can be drained.

---
 rtl/mod_port_pkg.sv | 8 +
 rtl/mod_port_mem.sv | 30 +++
 rtl/mod_port.sv | 70 +++++++
 tb/tb_mod_port.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mod_port_pkg.sv
// Shared sizing constants and the occupancy type for the mod_port FIFO.
package mod_port_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 32;
    localparam int ADDR_WIDTH = 5;

    typedef logic [ADDR_WIDTH:0] level_t;
endpackage

// File: rtl/mod_port_mem.sv
// 32x32 storage array: synchronous write, registered read, synchronous clear.
module mod_port_mem
    import mod_port_pkg::*;
(
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // A clear wins over a write landing on the same edge.
    always_ff @(posedge wclk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge wclk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/mod_port.sv
// Single-clock FIFO with write-side status: level, full/almost-full, overflow/underflow, write count.
// Handshake: a write is taken when write_enable && !wfull, a read when read_enable && !rempty,
// both judged on the registered flags at the edge; refused requests pulse overflow/underflow.
module mod_port
    import mod_port_pkg::*;
(
    input  logic                  wclk,
    input  logic                  sw_rst,
    input  logic                  mem_rst,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] afull_value,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty,
    output logic                  underflow,
    output logic                  wfull,
    output logic                  wr_almost_ful,
    output logic                  overflow,
    output logic [5:0]            fifo_write_count,
    output logic [5:0]            wr_level
);
    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
    level_t              level, next_level;
    logic                wr_acc, rd_acc;

    // Requests in the reset cycle are dropped entirely.
    assign wr_acc     = write_enable && !wfull  && !sw_rst;
    assign rd_acc     = read_enable  && !rempty && !sw_rst;
    assign next_level = level + level_t'(wr_acc) - level_t'(rd_acc);
    assign wr_level   = level;

    mod_port_mem u_mem (
        .wclk  (wclk),
        .rst   (sw_rst),
        .clr   (mem_rst),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (wdata),
        .re    (rd_acc),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge wclk) begin
        if (sw_rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            level            <= '0;
            fifo_write_count <= '0;
            wfull            <= 1'b0;
            rempty           <= 1'b1;
            wr_almost_ful    <= 1'b0;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr           <= wr_ptr + 1'b1;
                fifo_write_count <= fifo_write_count + 1'b1;
            end
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            level         <= next_level;
            wfull         <= (next_level == level_t'(DEPTH));
            rempty        <= (next_level == '0);
            wr_almost_ful <= (next_level >= {1'b0, afull_value});
            overflow      <= write_enable && wfull;
            underflow     <= read_enable && rempty;
        end
    end
endmodule

// File: tb/tb_mod_port.sv
// Directed bench for mod_port: queue-based FIFO model checked every cycle plus literal spot checks.
module tb_mod_port;
    logic        wclk = 0;
    logic        sw_rst = 0, mem_rst = 0;
    logic [31:0] wdata = 0;
    logic        write_enable = 0, read_enable = 0;
    logic [4:0]  afull_value = 5'd28;
    logic [31:0] rdata;
    logic        rempty, underflow, wfull, wr_almost_ful, overflow;
    logic [5:0]  fifo_write_count, wr_level;

    int checks = 0;
    int failures = 0;

    mod_port dut (
        .wclk(wclk), .sw_rst(sw_rst), .mem_rst(mem_rst), .wdata(wdata),
        .write_enable(write_enable), .afull_value(afull_value), .read_enable(read_enable),
        .rdata(rdata), .rempty(rempty), .underflow(underflow), .wfull(wfull),
        .wr_almost_ful(wr_almost_ful), .overflow(overflow),
        .fifo_write_count(fifo_write_count), .wr_level(wr_level)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO contents as a queue, outputs derived from its size.
    logic [31:0] q[$];
    logic [31:0] m_rdata;
    int          m_count;
    logic        m_over, m_under, m_af;
    bit          model_valid = 0;

    always @(posedge wclk) begin
        if (sw_rst) begin
            q.delete();
            m_count = 0; m_rdata = 0; m_over = 0; m_under = 0; m_af = 0;
            model_valid = 1;
        end else begin
            bit full, empty;
            full  = (q.size() == 32);
            empty = (q.size() == 0);
            m_over  = write_enable && full;
            m_under = read_enable && empty;
            if (read_enable && !empty) m_rdata = q.pop_front();
            if (mem_rst) foreach (q[i]) q[i] = 0;
            if (write_enable && !full) begin
                q.push_back(mem_rst ? 32'd0 : wdata);
                m_count = (m_count + 1) % 64;
            end
            m_af = (q.size() >= int'(afull_value));
        end
    end

    always @(negedge wclk) begin
        if (model_valid) begin
            check("cmp_level",  {26'd0, wr_level}, q.size());
            check("cmp_count",  {26'd0, fifo_write_count}, m_count);
            check("cmp_rdata",  rdata, m_rdata);
            check("cmp_wfull",  {31'd0, wfull}, (q.size() == 32));
            check("cmp_rempty", {31'd0, rempty}, (q.size() == 0));
            check("cmp_afull",  {31'd0, wr_almost_ful}, m_af);
            check("cmp_over",   {31'd0, overflow}, m_over);
            check("cmp_under",  {31'd0, underflow}, m_under);
        end
    end

    // Drive one cycle at the falling edge, return 1 time unit after the rising edge.
    task automatic cyc(input logic we, input logic [31:0] wd, input logic re,
                       input logic sr = 0, input logic mr = 0);
        @(negedge wclk);
        write_enable = we; wdata = wd; read_enable = re; sw_rst = sr; mem_rst = mr;
        @(posedge wclk);
        #1;
    endtask

    initial begin
        // Reset, clearing memory too
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        check("rst_level", {26'd0, wr_level}, 0);
        check("rst_count", {26'd0, fifo_write_count}, 0);
        check("rst_rempty", {31'd0, rempty}, 1);
        check("rst_wfull", {31'd0, wfull}, 0);
        check("rst_over", {31'd0, overflow}, 0);
        check("rst_rdata", rdata, 0);

        // Fill with 0..31
        for (int k = 0; k < 32; k++) begin
            cyc(1, k, 0);
            if (k == 26) check("afull_27", {31'd0, wr_almost_ful}, 0);
            if (k == 27) check("afull_28", {31'd0, wr_almost_ful}, 1);
            if (k == 30) check("wfull_31", {31'd0, wfull}, 0);
        end
        check("fill_wfull", {31'd0, wfull}, 1);
        check("fill_level", {26'd0, wr_level}, 32);
        check("fill_count", {26'd0, fifo_write_count}, 32);

        // Overflow
        cyc(1, 32'hDEAD, 0);
        check("ovf_pulse", {31'd0, overflow}, 1);
        check("ovf_level", {26'd0, wr_level}, 32);
        cyc(0, 0, 0);
        check("ovf_clear", {31'd0, overflow}, 0);
        check("ovf_count", {26'd0, fifo_write_count}, 32);

        // Read+write at full
        cyc(1, 32'hBEEF, 1);
        check("full_rw_rdata", rdata, 0);
        check("full_rw_over", {31'd0, overflow}, 1);
        check("full_rw_level", {26'd0, wr_level}, 31);
        for (int k = 1; k < 32; k++) begin
            cyc(0, 0, 1);
            check("drain_rdata", rdata, k);
        end
        check("drain_rempty", {31'd0, rempty}, 1);

        // Read+write at empty
        cyc(1, 32'h55, 1);
        check("empty_rw_under", {31'd0, underflow}, 1);
        check("empty_rw_level", {26'd0, wr_level}, 1);
        check("empty_rw_rdata", rdata, 31);
        cyc(0, 0, 1);
        check("empty_rw_data", rdata, 32'h55);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        check("under_b2b", {31'd0, underflow}, 1);

        // Wrap: 70 writes interleaved with reads
        cyc(0, 0, 0, 1);
        for (int k = 0; k < 70; k++) cyc(1, 32'h100 + k, k > 0);
        cyc(0, 0, 1);
        check("wrap_count", {26'd0, fifo_write_count}, 6);
        check("wrap_last", rdata, 32'h100 + 69);

        // Mid-operation sw_rst at level 10 with a write pending, then afull_value = 0
        for (int k = 0; k < 10; k++) cyc(1, 32'h200 + k, 0);
        check("pre_rst_level", {26'd0, wr_level}, 10);
        afull_value = 5'd0;
        cyc(1, 32'h999, 0, 1);
        check("midrst_level", {26'd0, wr_level}, 0);
        check("midrst_rempty", {31'd0, rempty}, 1);
        check("midrst_count", {26'd0, fifo_write_count}, 0);
        cyc(0, 0, 0);
        check("afull_zero", {31'd0, wr_almost_ful}, 1);
        afull_value = 5'd28;

        // mem_rst alone at level 5
        for (int k = 0; k < 5; k++) cyc(1, 32'hA0 + k, 0);
        cyc(0, 0, 0, 0, 1);
        check("memrst_level", {26'd0, wr_level}, 5);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 1);
            check("memrst_rdata", rdata, 0);
        end
        cyc(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
